// File: rtl/ip_pkg.sv
// Shared IPv4 transmit definitions: FSM states, header constants and
// one's-complement arithmetic helpers.
package ip_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHKS,
        HDR_1,
        HDR_2,
        HDR_3,
        HDR_4,
        HDR_5,
        DATA,
        FIN
    } state_t;

    localparam logic [3:0]  IP_VERSION     = 4'd4;
    localparam logic [3:0]  IHL_MIN        = 4'd5;
    localparam logic [15:0] IP_HDR_BYTES   = 16'd20;
    localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

    localparam logic [7:0] PROTO_ICMP = 8'd1;
    localparam logic [7:0] PROTO_TCP  = 8'd6;
    localparam logic [7:0] PROTO_UDP  = 8'd17;

    // 16-bit add with the carry folded back in; a second carry cannot occur
    function automatic logic [15:0] one_complement_adder(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [31:0] tail_mask(input logic [1:0] len_mod);
        logic [31:0] m;
        unique case (len_mod)
            2'd1:    m = 32'hFF00_0000;
            2'd2:    m = 32'hFFFF_0000;
            2'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ip_header_checksum.sv
// IPv4 header checksum: end-around-carry sum of ten halfwords, inverted.
// The checksum halfword slot is expected to be driven with zero.
module ip_header_checksum
    import ip_pkg::*;
(
    input  logic [159:0] halfwords,
    output logic [15:0]  checksum
);

    logic [15:0] sum;

    always_comb begin
        sum = 16'd0;
        for (int i = 0; i < 10; i++) begin
            sum = one_complement_adder(sum, halfwords[i*16 +: 16]);
        end
        checksum = ~sum;
    end

endmodule

// File: rtl/ip_encoder.sv
// IPv4 transmit encoder: 20-byte header then payload pulled from a FIFO.
// Optional IP_ENC_TTL_DEFAULT_EN substitutes DEFAULT_TTL for a zero TTL.
module ip_encoder
    import ip_pkg::*;
#(
    parameter logic [7:0] DEFAULT_TTL = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  type_of_ser,
    input  logic [15:0] identification,
    input  logic [2:0]  flag,
    input  logic [12:0] frag_offset,
    input  logic [7:0]  time_to_live,
    input  logic [7:0]  protocol,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] payload_len,
    input  logic [31:0] data_in,
    output logic        rd_en,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        last,
    output logic        fin,
    output logic        err
);

    state_t state_q, state_d;

    logic [7:0]  tos_q, ttl_q, proto_q;
    logic [15:0] id_q, len_q;
    logic [2:0]  flag_q;
    logic [12:0] off_q;
    logic [31:0] src_q, dst_q;

    logic [15:0] rem_q;
    logic [15:0] rd_cnt_q;

    logic [16:0] len_plus3;
    logic [15:0] words_in;
    logic [15:0] total_len;
    logic [7:0]  ttl_eff;
    logic [15:0] checksum;

    logic [31:0] data_d;
    logic        valid_d, last_d, fin_d, err_d;
    logic        emit;

    assign len_plus3 = {1'b0, payload_len} + 17'd3;
    assign words_in  = {1'b0, len_plus3[16:2]};
    assign total_len = len_q + IP_HDR_BYTES;

`ifdef IP_ENC_TTL_DEFAULT_EN
    assign ttl_eff = (ttl_q == 8'd0) ? DEFAULT_TTL : ttl_q;
`else
    assign ttl_eff = ttl_q;
    logic unused_default_ttl;
    assign unused_default_ttl = ^DEFAULT_TTL;
`endif

    ip_header_checksum u_csum (
        .halfwords ({IP_VERSION, IHL_MIN, tos_q, total_len,
                     id_q, flag_q, off_q,
                     ttl_eff, proto_q, 16'h0000,
                     src_q, dst_q}),
        .checksum  (checksum)
    );

    // Outputs are computed for the state being entered and registered with it
    always_comb begin
        state_d = state_q;
        data_d  = data_out;
        valid_d = 1'b0;
        last_d  = 1'b0;
        fin_d   = 1'b0;
        err_d   = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (payload_len > IP_MAX_PAYLOAD) begin
                        state_d = FIN;
                        fin_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = CHKS;
                    end
                end
            end
            CHKS: begin
                state_d = HDR_1;
                valid_d = 1'b1;
                data_d  = {IP_VERSION, IHL_MIN, tos_q, total_len};
            end
            HDR_1: begin
                state_d = HDR_2;
                valid_d = 1'b1;
                data_d  = {id_q, flag_q, off_q};
            end
            HDR_2: begin
                state_d = HDR_3;
                valid_d = 1'b1;
                data_d  = {ttl_eff, proto_q, checksum};
            end
            HDR_3: begin
                state_d = HDR_4;
                valid_d = 1'b1;
                data_d  = src_q;
            end
            HDR_4: begin
                state_d = HDR_5;
                valid_d = 1'b1;
                last_d  = (rem_q == 16'd0);
                data_d  = dst_q;
            end
            HDR_5, DATA: begin
                if (rem_q == 16'd0) begin
                    state_d = FIN;
                    fin_d   = 1'b1;
                end else begin
                    state_d = DATA;
                    valid_d = 1'b1;
                    emit    = 1'b1;
                    last_d  = (rem_q == 16'd1);
                    data_d  = (rem_q == 16'd1)
                            ? (data_in & tail_mask(len_q[1:0]))
                            : data_in;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_out <= 32'd0;
            valid    <= 1'b0;
            last     <= 1'b0;
            fin      <= 1'b0;
            err      <= 1'b0;
            rd_en    <= 1'b0;
            rem_q    <= 16'd0;
            rd_cnt_q <= 16'd0;
            tos_q    <= 8'd0;
            ttl_q    <= 8'd0;
            proto_q  <= 8'd0;
            id_q     <= 16'd0;
            len_q    <= 16'd0;
            flag_q   <= 3'd0;
            off_q    <= 13'd0;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            data_out <= data_d;
            valid    <= valid_d;
            last     <= last_d;
            fin      <= fin_d;
            err      <= err_d;

            if (state_q == IDLE && start) begin
                tos_q   <= type_of_ser;
                ttl_q   <= time_to_live;
                proto_q <= protocol;
                id_q    <= identification;
                len_q   <= payload_len;
                flag_q  <= flag;
                off_q   <= frag_offset;
                src_q   <= src_ip;
                dst_q   <= dest_ip;
                rem_q   <= words_in;
            end else if (emit) begin
                rem_q <= rem_q - 16'd1;
            end

            // Reads run two cycles ahead of the DATA words they feed
            if (state_q == HDR_3) begin
                rd_en    <= (rem_q != 16'd0);
                rd_cnt_q <= rem_q;
            end else if (rd_en) begin
                rd_cnt_q <= rd_cnt_q - 16'd1;
                if (rd_cnt_q == 16'd1) begin
                    rd_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_encoder.sv
// Self-checking bench for ip_encoder: cycle-timed datagram model plus
// hand-computed header literals.
module tb_ip_encoder;
    import ip_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  type_of_ser = 8'd0;
    logic [15:0] identification = 16'd0;
    logic [2:0]  flag = 3'd0;
    logic [12:0] frag_offset = 13'd0;
    logic [7:0]  time_to_live = 8'd0;
    logic [7:0]  protocol = 8'd0;
    logic [31:0] src_ip = 32'd0;
    logic [31:0] dest_ip = 32'd0;
    logic [15:0] payload_len = 16'd0;
    logic [31:0] data_in = 32'd0;
    logic        rd_en;
    logic [31:0] data_out;
    logic        valid, last, fin, err;

    always #5 clk = ~clk;

    ip_encoder dut (
        .clk(clk), .reset(reset), .start(start),
        .type_of_ser(type_of_ser), .identification(identification),
        .flag(flag), .frag_offset(frag_offset),
        .time_to_live(time_to_live), .protocol(protocol),
        .src_ip(src_ip), .dest_ip(dest_ip), .payload_len(payload_len),
        .data_in(data_in), .rd_en(rd_en), .data_out(data_out),
        .valid(valid), .last(last), .fin(fin), .err(err)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rp = 0;
    int rp_base = 0;
    int t0 = -1;
    int abort_t = 1 << 30;

    logic [7:0]  m_tos, m_ttl, m_proto;
    logic [15:0] m_id, m_len;
    logic [2:0]  m_flag;
    logic [12:0] m_off;
    logic [31:0] m_src, m_dst;
    bit          m_err;
    int          m_n;
    logic [31:0] cap [5];

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, 8'h5A, ~b, 8'hFF};
    endfunction

    // Upstream FIFO with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            data_in <= pat(rp - rp_base);
            rp <= rp + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_ttl();
        logic [7:0] v;
        v = m_ttl;
`ifdef IP_ENC_TTL_DEFAULT_EN
        if (v == 8'd0) v = 8'd64;
`endif
        return v;
    endfunction

    function automatic logic [15:0] model_csum();
        int s;
        logic [15:0] r;
        s = 32'h4500 + int'(m_tos) + int'(m_len) + 20 + int'(m_id)
          + int'({m_flag, m_off}) + int'({model_ttl(), m_proto})
          + int'(m_src[31:16]) + int'(m_src[15:0])
          + int'(m_dst[31:16]) + int'(m_dst[15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        r = s[15:0];
        return ~r;
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        int j, keep;
        case (k)
            0: w = {8'h45, m_tos, m_len + 16'd20};
            1: w = {m_id, m_flag, m_off};
            2: w = {model_ttl(), m_proto, model_csum()};
            3: w = m_src;
            4: w = m_dst;
            default: begin
                j = k - 5;
                w = pat(j);
                if (j == m_n - 1) begin
                    keep = int'(m_len) % 4;
                    if (keep == 0) keep = 4;
                    for (int b = keep; b < 4; b++) w[31 - 8*b -: 8] = 8'h00;
                end
            end
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int t;
        logic ev, el, ef, ee, er;
        if (cyc >= 1) begin
            ev = 0; el = 0; ef = 0; ee = 0; er = 0; t = -1;
            if (t0 >= 0) begin
                t = cyc - t0;
                if (t <= abort_t) begin
                    if (m_err) begin
                        ef = (t == 1);
                        ee = (t == 1);
                    end else begin
                        ev = (t >= 2 && t <= 6 + m_n);
                        el = (t == 6 + m_n);
                        ef = (t == 7 + m_n);
                        er = (t >= 5 && t <= 4 + m_n);
                    end
                end
            end
            chk("valid", valid, ev);
            chk("last", last, el);
            chk("fin", fin, ef);
            chk("err", err, ee);
            chk("rd_en", rd_en, er);
            if (ev) chk("data", data_out, exp_word(t - 2));
            if (valid && t >= 2 && t <= 6) cap[t - 2] = data_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] len, input logic [7:0] ttl,
                          input logic [7:0] tos, input logic [15:0] id);
        type_of_ser = tos;       m_tos = tos;
        identification = id;     m_id = id;
        flag = 3'b010;           m_flag = 3'b010;
        frag_offset = 13'd0;     m_off = 13'd0;
        time_to_live = ttl;      m_ttl = ttl;
        protocol = PROTO_UDP;    m_proto = PROTO_UDP;
        src_ip = 32'hC0A80001;   m_src = 32'hC0A80001;
        dest_ip = 32'hC0A800C7;  m_dst = 32'hC0A800C7;
        payload_len = len;       m_len = len;
        m_err = (len > 16'd65515);
        m_n = (int'(len) + 3) >> 2;
        rp_base = rp;
        abort_t = 1 << 30;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        type_of_ser = 8'($urandom);
        identification = 16'($urandom);
        flag = 3'($urandom);
        frag_offset = 13'($urandom);
        time_to_live = 8'($urandom);
        protocol = 8'($urandom);
        src_ip = $urandom;
        dest_ip = $urandom;
        payload_len = 16'($urandom);
    endtask

    initial begin
        int lens [6];
        lens = '{1, 2, 3, 4, 5, 8};
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reference vector, start pulsed in DATA and in FIN
        launch(16'd95, 8'h40, 8'h00, 16'h0000);
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hdr1", cap[0], 32'h45000073);
        chk("hdr2", cap[1], 32'h00004000);
        chk("hdr3", cap[2], 32'h4011B861);
        chk("hdr4", cap[3], 32'hC0A80001);
        chk("hdr5", cap[4], 32'hC0A800C7);
        repeat (3) tick();

        launch(16'd0, 8'h20, 8'h10, 16'h1234);
        repeat (10) tick();

        launch(16'd65516, 8'h40, 8'h00, 16'h0001);
        repeat (4) tick();

        foreach (lens[i]) begin
            launch(16'(lens[i]), 8'h80, 8'(i), 16'(i * 257));
            repeat (9 + m_n) tick();
        end

        launch(16'd65515, 8'h40, 8'h00, 16'h0000);
        repeat (9 + m_n) tick();
        chk("maxlen_hdr1", cap[0], 32'h4500FFFF);

        // Reset while streaming payload
        launch(16'd40, 8'h40, 8'h00, 16'h0042);
        repeat (8) tick();
        reset = 1'b1;
        abort_t = cyc - t0;
        tick();
        chk("rst_data", data_out, 32'd0);
        reset = 1'b0;
        tick();
        launch(16'd12, 8'h40, 8'h00, 16'h0043);
        repeat (12) tick();

        launch(16'd95, 8'h00, 8'h00, 16'h0000);
        repeat (32) tick();
`ifdef IP_ENC_TTL_DEFAULT_EN
        chk("ttl0_hdr3", cap[2], 32'h4011B861);
`else
        chk("ttl0_hdr3", cap[2], 32'h0011F861);
`endif
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
